jam_cost_buffer: RTL and testbench

Upstream feeder for the JAM job-assignment solver. Accepts the 8×8 worker/job cost matrix as a 64-beat valid/ready stream and stores it in a local table. Serves the solver's W/J random-access reads with the one-cycle registered latency the solver expects. While loading, it also computes per-worker row minima and their sum, a lower bound on MinCost used for pruning and checking.

---
 rtl/jam_pkg.sv | 19 +
 rtl/jam_rowmin.sv | 36 +++
 rtl/jam_cost_buffer.sv | 112 +++++++++++
 tb/tb_jam_cost_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared types and sizes for the JAM solver and its cost-matrix feeder.
package jam_pkg;

  localparam int unsigned COST_W = 7;
  localparam int unsigned N      = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned K_W    = 2 * IDX_W;

  typedef logic [COST_W-1:0] cost_t;
  typedef logic [SUM_W-1:0]  sum_t;
  typedef logic [K_W-1:0]    beat_t;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } buf_state_e;

endpackage

// File: rtl/jam_rowmin.sv
// Running minimum over one worker row; flags the row result on its last beat.
module jam_rowmin
  import jam_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  beat_valid,
  input  cost_t cost,
  input  logic  first,
  input  logic  last,
  output cost_t row_min_c,
  output logic  row_done_c
);

  cost_t min_q;
  cost_t min_d;

  // First beat of a row restarts the minimum; later beats fold in.
  always_comb begin
    row_min_c  = (first || (cost < min_q)) ? cost : min_q;
    row_done_c = beat_valid && last;
    min_d      = min_q;
    if (beat_valid) begin
      min_d = row_min_c;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      min_q <= '0;
    end else begin
      min_q <= min_d;
    end
  end

endmodule

// File: rtl/jam_cost_buffer.sv
// Loads the 8x8 cost matrix from a valid/ready stream, serves registered
// W/J reads and accumulates the row-minimum lower bound during the load.
module jam_cost_buffer
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  cost_t            in_cost,
  input  logic             in_last,
  input  logic             reload,
  input  logic [IDX_W-1:0] W,
  input  logic [IDX_W-1:0] J,
  output cost_t            Cost,
  output logic             table_valid,
  output sum_t             LowerBound,
  output logic             err
);

  buf_state_e state_q, state_d;
  beat_t      k_q, k_d;
  sum_t       acc_q, acc_d;
  logic       err_q, err_d;
  cost_t      cost_q, cost_d;
  cost_t      tbl_q [N*N];
  cost_t      tbl_d [N*N];

  logic       beat_acc;
  logic       last_slot;
  logic       frame_err;
  logic       row_first;
  logic       row_last;
  cost_t      row_min_c;
  logic       row_done_c;

  assign in_ready    = (state_q == LOAD) && !reload;
  assign beat_acc    = in_valid && in_ready;
  assign last_slot   = (k_q == '1);
  assign frame_err   = beat_acc && (in_last != last_slot);
  assign row_first   = (k_q[IDX_W-1:0] == '0);
  assign row_last    = (k_q[IDX_W-1:0] == '1);

  assign Cost        = cost_q;
  assign table_valid = (state_q == READY);
  assign LowerBound  = acc_q;
  assign err         = err_q;

  jam_rowmin u_rowmin (
    .CLK        (CLK),
    .RST        (RST),
    .beat_valid (beat_acc),
    .cost       (in_cost),
    .first      (row_first),
    .last       (row_last),
    .row_min_c  (row_min_c),
    .row_done_c (row_done_c)
  );

  // Next-state: reload wins over any beat; a framing error restarts the count
  // but leaves already-written slots in place.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    err_d   = err_q;
    tbl_d   = tbl_q;
    cost_d  = tbl_q[{W, J}];

    if (reload) begin
      state_d = LOAD;
      k_d     = '0;
      acc_d   = '0;
    end else if (beat_acc) begin
      tbl_d[k_q] = in_cost;
      if (frame_err) begin
        err_d = 1'b1;
        k_d   = '0;
        acc_d = '0;
      end else begin
        k_d = k_q + K_W'(1);
        if (row_done_c) begin
          acc_d = acc_q + SUM_W'(row_min_c);
        end
        if (last_slot) begin
          state_d = READY;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LOAD;
      k_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      cost_q  <= '0;
      for (int i = 0; i < N*N; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      cost_q  <= cost_d;
      tbl_q   <= tbl_d;
    end
  end

endmodule

// File: tb/tb_jam_cost_buffer.sv
// Self-checking bench for jam_cost_buffer: directed tables plus randomized
// loads compared against a matrix-level reference model.
module tb_jam_cost_buffer;
  import jam_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        reload = 1'b0;
  cost_t       in_cost = '0;
  logic [2:0]  W = '0;
  logic [2:0]  J = '0;
  logic        in_ready;
  logic        table_valid;
  logic        err;
  cost_t       Cost;
  sum_t        LowerBound;

  always #5 CLK = ~CLK;

  jam_cost_buffer dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cost     (in_cost),
    .in_last     (in_last),
    .reload      (reload),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .table_valid (table_valid),
    .LowerBound  (LowerBound),
    .err         (err)
  );

  int    n_vec = 0;
  int    n_bad = 0;
  cost_t m_tab [8][8];
  int    m_k;
  bit    m_ready;
  bit    m_err;
  int    m_cost;
  logic  rdy_seen;
  cost_t src [64];

  typedef struct {
    logic       v;
    logic       r;
    logic [2:0] w;
    logic [2:0] j;
    int         exp_cost;
    logic       exp_tv;
    logic       exp_rdy;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m_tab[r][c] = '0;
    m_k = 0; m_ready = 0; m_err = 0; m_cost = 0;
  endtask

  // Bound = sum of minima over rows fully written in the current load.
  function automatic int model_lb();
    int s = 0;
    int rows;
    rows = m_ready ? 8 : m_k / 8;
    for (int r = 0; r < rows; r++) begin
      int mn;
      mn = int'(m_tab[r][0]);
      for (int c = 1; c < 8; c++) if (int'(m_tab[r][c]) < mn) mn = int'(m_tab[r][c]);
      s += mn;
    end
    return s;
  endfunction

  task automatic cycle(input logic v, input cost_t c, input logic l, input logic r,
                       input logic [2:0] w, input logic [2:0] j);
    bit rdy;
    @(negedge CLK);
    in_valid = v; in_cost = c; in_last = l; reload = r; W = w; J = j;
    #1;
    rdy = !m_ready && !r;
    rdy_seen = in_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    m_cost = int'(m_tab[w][j]);
    if (r) begin
      m_k = 0; m_ready = 0;
    end else if (v && rdy) begin
      m_tab[m_k/8][m_k%8] = c;
      if (l != (m_k == 63)) begin
        m_err = 1; m_k = 0;
      end else if (m_k == 63) begin
        m_k = 0; m_ready = 1;
      end else begin
        m_k++;
      end
    end
    @(posedge CLK);
    #1;
    chk("Cost", 32'(Cost), 32'(m_cost));
    chk("table_valid", 32'(table_valid), 32'(m_ready));
    chk("LowerBound", 32'(LowerBound), 32'(model_lb()));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Stream src[] as one matrix; gaps randomizes in_valid, follow reads the slot being written.
  task automatic load(input bit gaps, input bit follow);
    int k = 0;
    int guard = 0;
    while (k < 64 && guard < 2000) begin
      logic v;
      logic [2:0] w, j;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      w = follow ? 3'(k / 8) : 3'($urandom_range(0, 7));
      j = follow ? 3'(k % 8) : 3'($urandom_range(0, 7));
      cycle(v, src[k], 1'(k == 63), 1'b0, w, j);
      if (v) k++;
      guard++;
    end
    chk("load_guard", 32'(k), 32'd64);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_cost", 32'(Cost), 32'd0);
    chk("rst_tv", 32'(table_valid), 32'd0);
    chk("rst_lb", 32'(LowerBound), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Ramp matrix 8w+j+1
    for (int i = 0; i < 64; i++) src[i] = cost_t'(i + 1);
    load(1'b0, 1'b0);
    chk("ramp_lb", 32'(LowerBound), 32'd232);
    chk("ramp_tv", 32'(table_valid), 32'd1);

    vt[0] = '{v: 1'b1, r: 1'b0, w: 3'd3, j: 3'd5, exp_cost: 30, exp_tv: 1'b1, exp_rdy: 1'b0};
    vt[1] = '{v: 1'b0, r: 1'b0, w: 3'd0, j: 3'd0, exp_cost: 1,  exp_tv: 1'b1, exp_rdy: 1'b0};
    vt[2] = '{v: 1'b1, r: 1'b0, w: 3'd7, j: 3'd7, exp_cost: 64, exp_tv: 1'b1, exp_rdy: 1'b0};
    vt[3] = '{v: 1'b0, r: 1'b1, w: 3'd2, j: 3'd2, exp_cost: 19, exp_tv: 1'b0, exp_rdy: 1'b0};
    vt[4] = '{v: 1'b0, r: 1'b0, w: 3'd3, j: 3'd5, exp_cost: 30, exp_tv: 1'b0, exp_rdy: 1'b1};
    for (int i = 0; i < 5; i++) begin
      cycle(vt[i].v, 7'd99, 1'b1, vt[i].r, vt[i].w, vt[i].j);
      chk("vec_ready", 32'(rdy_seen), 32'(vt[i].exp_rdy));
      chk("vec_cost", 32'(Cost), 32'(vt[i].exp_cost));
      chk("vec_tv", 32'(table_valid), 32'(vt[i].exp_tv));
    end

    // All 127, reading the slot under write (old ramp values expected)
    for (int i = 0; i < 64; i++) src[i] = 7'd127;
    load(1'b0, 1'b1);
    chk("max_lb", 32'(LowerBound), 32'd1016);

    // Early in_last on beat 10
    cycle(1'b0, '0, 1'b0, 1'b1, 3'd0, 3'd0);
    for (int i = 0; i <= 10; i++) cycle(1'b1, cost_t'(i + 3), 1'(i == 10), 1'b0, 3'd0, 3'd0);
    chk("ferr_err", 32'(err), 32'd1);
    chk("ferr_tv", 32'(table_valid), 32'd0);
    chk("ferr_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 64; i++) src[i] = cost_t'($urandom_range(0, 127));
    load(1'b0, 1'b0);
    chk("ferr_tv_after", 32'(table_valid), 32'd1);
    chk("ferr_sticky", 32'(err), 32'd1);

    // Missing in_last on beat 63
    cycle(1'b0, '0, 1'b0, 1'b1, 3'd0, 3'd0);
    for (int i = 0; i < 64; i++) cycle(1'b1, cost_t'($urandom_range(0, 127)), 1'b0, 1'b0, 3'd1, 3'd1);
    chk("nolast_tv", 32'(table_valid), 32'd0);

    // Random matrix with in_valid gaps, then extra beats and full readback in READY
    cycle(1'b0, '0, 1'b0, 1'b1, 3'd0, 3'd0);
    for (int i = 0; i < 64; i++) src[i] = cost_t'($urandom_range(0, 127));
    load(1'b1, 1'b0);
    for (int i = 0; i < 64; i++) cycle(1'b1, cost_t'($urandom), 1'b1, 1'b0, 3'(i / 8), 3'(i % 8));

    // Reload to all-5
    cycle(1'b0, '0, 1'b0, 1'b1, 3'd0, 3'd0);
    chk("reload_tv", 32'(table_valid), 32'd0);
    for (int i = 0; i < 64; i++) src[i] = 7'd5;
    load(1'b0, 1'b0);
    chk("five_lb", 32'(LowerBound), 32'd40);

    // Reset mid-load after beat 30
    cycle(1'b0, '0, 1'b0, 1'b1, 3'd0, 3'd0);
    for (int i = 0; i <= 30; i++) cycle(1'b1, cost_t'(i + 20), 1'b0, 1'b0, 3'd2, 3'd3);
    @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0; reload = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk("amid_ready", 32'(in_ready), 32'd1);
    chk("amid_cost", 32'(Cost), 32'd0);
    chk("amid_tv", 32'(table_valid), 32'd0);
    chk("amid_lb", 32'(LowerBound), 32'd0);
    chk("amid_err", 32'(err), 32'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, 3'd2, 3'd3);
    chk("post_rst_cost", 32'(Cost), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
